// File: rtl/uart_rx_fifo_if.sv
// Receive-side handshake bundle: FIFO head byte out, consumer ready in, plus status flags.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection, break hold-off,
// and a first-word-fall-through byte FIFO on a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           rxd,
  uart_rx_fifo_if.master rx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL    = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta, rxs;
  logic [1:0]    sync_fill;
  logic          armed;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ferr_q, ovr_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop, wr_ok;

  // rxs only means something once both sync flops hold real pin samples; a start is
  // accepted only after the line has been seen high, so a frame cut by reset is skipped.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rxd;
      rxs       <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rxs) armed <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state)
        S_IDLE: if (armed && !rxs) begin
          state <= S_START;
          cnt   <= '0;
        end
        S_START: if (cnt == HALF_M1) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rxs ? S_IDLE : S_DATA;
        end else cnt <= cnt + CW'(1);
        S_DATA: if (cnt == LAST) begin
          cnt     <= '0;
          shreg   <= {rxs, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= S_STOP;
        end else cnt <= cnt + CW'(1);
        S_STOP: if (cnt == LAST) begin
          cnt <= '0;
          if (rxs) state <= S_IDLE;
          else begin
            ferr_q <= 1'b1;
            state  <= S_BREAK;
          end
        end else cnt <= cnt + CW'(1);
        S_BREAK: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign push  = (state == S_STOP) && (cnt == LAST) && rxs;
  assign pop   = rx_if.rx_valid && rx_if.rx_ready;
  // A full FIFO still takes the byte if the head leaves on the same edge.
  assign wr_ok = push && ((count != FULL) || pop);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !wr_ok) ovr_q <= 1'b1;
    end
  end

  assign rx_if.rx_valid  = (count != '0);
  assign rx_if.rx_data   = mem[rd_ptr];
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed serial frames, a queue-based reference of received
// bytes checked every cycle, and literal expectations for latency, order and flags.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int HALF  = CPB / 2;
  // Edges from the edge before the start bit is driven to the edge after the stop sample.
  localparam int LAT   = 3 + HALF + 9 * CPB;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic rxd      = 1'b1;
  uart_rx_fifo_if rx_if();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .rxd(rxd), .rx_if(rx_if));

  always #10 CLOCK_50 = ~CLOCK_50;

  int ecnt = 0;
  always @(posedge CLOCK_50) ecnt <= ecnt + 1;

  typedef struct { int edge_n; logic [7:0] data; bit good; } ev_t;
  ev_t        evq[$];
  logic [7:0] m_q[$];
  bit         m_ovr = 0, m_ferr = 0, chk_en = 0;
  int         n_chk = 0, n_pass = 0;
  int         last_pe = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Reference: bytes arrive when their frame completes; the consumer removes the head
  // whenever it is ready; a full buffer refuses new bytes unless the head leaves too.
  always @(negedge CLOCK_50) if (chk_en) begin
    chk("valid", rx_if.rx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("data", rx_if.rx_data, m_q[0]);
    chk("frame_err", rx_if.frame_err, m_ferr);
    chk("overrun", rx_if.overrun, m_ovr);
    if (reset) begin
      m_q.delete(); evq.delete(); m_ovr = 0; m_ferr = 0;
    end else begin
      m_ferr = 0;
      if (m_q.size() != 0 && rx_if.rx_ready) void'(m_q.pop_front());
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].edge_n == ecnt + 1) begin
          if (!evq[i].good) m_ferr = 1;
          else if (m_q.size() < DEPTH) m_q.push_back(evq[i].data);
          else m_ovr = 1;
          evq.delete(i);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop);
    last_pe = ecnt + LAT;
    evq.push_back('{last_pe, b, stop});
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; tick(CPB); end
    rxd = stop; tick(CPB);
  endtask

  task automatic drain(input logic [7:0] e [4], input int n);
    rx_if.rx_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk("drain_valid", rx_if.rx_valid, 1);
      chk("drain_data", rx_if.rx_data, e[k]);
      tick(1);
    end
    rx_if.rx_ready = 1'b0;
    chk("drain_empty", rx_if.rx_valid, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n0, lat, hi, pe;
  logic [7:0] got;

  initial begin
    rx_if.rx_ready = 1'b0;
    tick(3);
    chk_en = 1;
    reset  = 1'b0;
    chk("rst_valid", rx_if.rx_valid, 0);
    chk("rst_data", rx_if.rx_data, 8'h00);
    chk("rst_ferr", rx_if.frame_err, 0);
    chk("rst_ovr", rx_if.overrun, 0);
    tick(5);

    // Single frame consumed immediately.
    rx_if.rx_ready = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n0 = ecnt; lat = -1; got = 8'h00;
        for (int k = 0; k < 300 && lat < 0; k++) begin
          tick(1);
          if (rx_if.rx_valid) begin lat = ecnt - n0; got = rx_if.rx_data; end
        end
        hi = (lat >= 0) ? 1 : 0;
        for (int k = 0; k < 5; k++) begin tick(1); if (rx_if.rx_valid) hi++; end
      end
    join
    chk("a5_latency_in_window", (lat >= 154 && lat <= 156), 1);
    chk("a5_data", got, 8'hA5);
    chk("a5_valid_cycles", hi, 1);
    rx_if.rx_ready = 1'b0;
    tick(2 * CPB);

    // Four back-to-back frames fill the FIFO, then drain one per cycle.
    send_frame(8'h00, 1'b1); send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1); send_frame(8'h81, 1'b1);
    tick(CPB);
    chk("full_valid", rx_if.rx_valid, 1);
    drain('{8'h00, 8'hFF, 8'h3C, 8'h81}, 4);

    // Stop bit low, line held low: one frame error, then a clean frame.
    send_frame(8'h55, 1'b0);
    tick(40 * CPB);
    rxd = 1'b1; tick(2 * CPB);
    send_frame(8'h12, 1'b1);
    drain('{8'h12, 8'h00, 8'h00, 8'h00}, 1);

    // Short start glitch is ignored.
    rxd = 1'b0; tick(6); rxd = 1'b1; tick(3 * CPB);
    send_frame(8'h7E, 1'b1);
    drain('{8'h7E, 8'h00, 8'h00, 8'h00}, 1);

    // Fifth byte into a full FIFO is dropped and overrun sticks.
    send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1); send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1); send_frame(8'h55, 1'b1);
    tick(CPB);
    chk("ovr_set", rx_if.overrun, 1);
    drain('{8'h11, 8'h22, 8'h33, 8'h44}, 4);
    tick(CPB);
    chk("ovr_sticky", rx_if.overrun, 1);

    // After reset, a push that coincides with a pop while full is accepted.
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("rst2_ovr", rx_if.overrun, 0);
    tick(4);
    send_frame(8'hA1, 1'b1); send_frame(8'hB2, 1'b1);
    send_frame(8'hC3, 1'b1); send_frame(8'hD4, 1'b1);
    fork
      send_frame(8'hE5, 1'b1);
      begin
        tick(1);
        pe = last_pe;
        while (ecnt < pe - 1) tick(1);
        rx_if.rx_ready = 1'b1; tick(1); rx_if.rx_ready = 1'b0;
      end
    join
    chk("coincide_no_ovr", rx_if.overrun, 0);
    drain('{8'hB2, 8'hC3, 8'hD4, 8'hE5}, 4);

    // Reset at bit 4 of a frame with one byte buffered.
    send_frame(8'h5A, 1'b1);
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) begin rxd = 1'b1; tick(CPB); end
    rxd = 1'b0; tick(HALF);
    chk("pre_rst_valid", rx_if.rx_valid, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("mid_rst_valid", rx_if.rx_valid, 0);
    chk("mid_rst_data", rx_if.rx_data, 8'h00);
    chk("mid_rst_ferr", rx_if.frame_err, 0);
    chk("mid_rst_ovr", rx_if.overrun, 0);
    tick(12);
    rxd = 1'b1; tick(3 * CPB);
    chk("no_partial_frame", rx_if.rx_valid, 0);
    send_frame(8'hC3, 1'b1);
    tick(2);
    drain('{8'hC3, 8'h00, 8'h00, 8'h00}, 1);
    tick(CPB);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte receiver for the board's UART_RXD pin, running on CLOCK_50. It samples 8N1 serial frames at mid-bit, rejects start-bit glitches and flags framing errors. Good bytes are buffered in a small first-word-fall-through FIFO and presented to on-chip logic through a valid/ready handshake. It is the inbound counterpart to the board's outbound display and status path, and feeds host command bytes into the design.

## Interface
Parameters:
- CLKS_PER_BIT, 434: CLOCK_50 cycles per bit (115200 baud); minimum 8. Benches use 16.
- FIFO_DEPTH, 4: entries, power of two, 2..16.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- rxd  in  1  asynchronous serial input (UART_RXD), idle high.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts head when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse, stop bit sampled low.
- overrun  out  1  sticky; a good byte was dropped because the FIFO was full. Cleared only by reset.

## Operation
- rxd passes through a 2-flop synchronizer, both flops reset to 1. All FSM decisions use the synchronized value rxs.
- Bit counter cnt counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2, using integer division.
- FSM states:
  - IDLE: when rxs=0, go to START with cnt=0.
  - START: at cnt=HALF-1, sample rxs. If 0, go to DATA with cnt=0 and bit index 0. If 1, treat as a glitch and return to IDLE with no flag.
  - DATA: at cnt=CLKS_PER_BIT-1, sample rxs into the shift register LSB-first and reset cnt. After the 8th sample, go to STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rxs. If 1, push the byte and go to IDLE. If 0, assert frame_err for one cycle, discard the byte, and go to BREAK.
  - BREAK: stay until rxs=1, then go to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- FIFO behaviour:
  - Circular buffer with read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
  - rx_data is driven from mem[rd_ptr].
  - A pop happens on any cycle where rx_valid & rx_ready.
  - A push when the FIFO is full and no pop occurs in the same cycle drops the byte, sets overrun, and leaves the FIFO contents unchanged.
  - A push and pop in the same cycle when the FIFO is full are both accepted; no overrun.
  - A push and pop in the same cycle when the FIFO is empty: only the push takes effect, and rx_valid rises on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values: FSM in IDLE; cnt, bit index and shift register 0; FIFO empty; rx_valid=0, rx_data=0 (memory reset to 0), frame_err=0, overrun=0.
- Reset asserted mid-frame abandons the partial byte and flushes the FIFO. After reset, a frame whose start edge was missed is not decoded until the line idles high.

## Timing
- Falling start edge at the pin to first rxs=0: 2 cycles.
- Falling start edge to rx_valid=1, with the FIFO empty: 2 + HALF + 9*CLKS_PER_BIT + 1 cycles (±1 for synchronizer phase).
  - CLKS_PER_BIT=434: 4126 cycles.
  - CLKS_PER_BIT=16: 155 cycles.
- frame_err pulses on the cycle after the stop-bit sample, at the same point rx_valid would have risen.
- Sampling happens mid-stop-bit and the FSM returns to IDLE immediately. A start bit following the stop bit with no idle gap is therefore caught, and back-to-back frames are sustained.
- The handshake is combinational on rx_ready. rx_data updates to the next entry on the cycle after a pop.
- Baud tolerance: up to ±4% cumulative mismatch is decoded correctly.

## Test plan
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Single frame 0xA5, rx_ready=1: rx_valid goes high for exactly 1 cycle about 155 cycles after the start edge with rx_data=0xA5; frame_err=0; overrun=0.
- Four back-to-back frames 0x00, 0xFF, 0x3C, 0x81 with no idle gap, rx_ready=0: rx_valid stays 1 and the FIFO is full. Raising rx_ready then drains the bytes in order, one per cycle; rx_valid=0 after the 4th pop.
- Five frames with rx_ready=0: the first four are retained, the 5th is dropped, overrun=1 and stays 1. Draining yields only the first four bytes. A push coinciding with a pop while full sets no overrun.
- Frame 0x55 with stop bit forced low, then line held low for 40 bit times: exactly one frame_err pulse, no push, FSM stays in BREAK. After the line goes high, the next 0x12 frame is received correctly.
- rxd low pulse of 6 cycles (less than HALF): no push and no frame_err. A 0x7E frame that follows is received.
- reset asserted for 1 cycle at bit 4 of a frame while one byte is buffered: next cycle rx_valid=0 and all outputs are at reset values. A clean 0xC3 frame afterwards is received.
